// File: rtl/cnn_dsp_pkg.sv
// Shared types, constants and helpers for the CNN multiply / multiply-accumulate datapath.
package cnn_dsp_pkg;

  localparam int unsigned DIN0_WIDTH_DEF = 10;
  localparam int unsigned DIN1_WIDTH_DEF = 14;
  localparam int unsigned PROD_WIDTH     = DIN0_WIDTH_DEF + DIN1_WIDTH_DEF;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  // Per-beat control that travels alongside the operands through the multiplier.
  typedef struct packed {
    logic valid;
    logic mode;
    logic first;
    logic last;
  } beat_tag_t;

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                   input int unsigned        width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      sat_clamp = max_v;
    end else if (value < min_v) begin
      sat_clamp = min_v;
    end else begin
      sat_clamp = value;
    end
  endfunction

endpackage

// File: rtl/cnn_mac_pipe_dsp_if.sv
// Operand/result bundle between the line-buffer/weight readers and the MAC unit.
interface cnn_mac_pipe_dsp_if #(
  parameter int unsigned DIN0_WIDTH = 10,
  parameter int unsigned DIN1_WIDTH = 14,
  parameter int unsigned ACC_WIDTH  = 32
);
  logic                         in_valid;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         first;
  logic                         last;
  logic                         acc_mode;
  logic                         out_valid;
  logic signed [ACC_WIDTH-1:0]  dout;
  logic                         out_last;
  logic                         ovf;

  modport master (
    output in_valid, din0, din1, first, last, acc_mode,
    input  out_valid, dout, out_last, ovf
  );

  modport slave (
    input  in_valid, din0, din1, first, last, acc_mode,
    output out_valid, dout, out_last, ovf
  );
endinterface

// File: rtl/cnn_mul_pipe_core.sv
// Signed multiplier with NUM_STAGE-1 enabled registers: one operand stage, then product stages.
module cnn_mul_pipe_core import cnn_dsp_pkg::*; #(
  parameter int unsigned DIN0_WIDTH = 10,
  parameter int unsigned DIN1_WIDTH = 14,
  parameter int unsigned NUM_STAGE  = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ce,
  input  logic signed [DIN0_WIDTH-1:0]           din0_i,
  input  logic signed [DIN1_WIDTH-1:0]           din1_i,
  input  beat_tag_t                              tag_i,
  output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0] prod_o,
  output beat_tag_t                              tag_o
);
  localparam int unsigned ProdWidth = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned ProdRegs  = NUM_STAGE - 2;

  logic signed [DIN0_WIDTH-1:0] a_q;
  logic signed [DIN1_WIDTH-1:0] b_q;
  logic signed [ProdWidth-1:0]  a_ext;
  logic signed [ProdWidth-1:0]  b_ext;
  logic signed [ProdWidth-1:0]  mult;
  beat_tag_t                    tag_q [NUM_STAGE-1];

  assign a_ext = ProdWidth'(a_q);
  assign b_ext = ProdWidth'(b_q);
  assign mult  = a_ext * b_ext;

  // Operand registers carry no reset so they can pack into the DSP input registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGE - 1; i++) tag_q[i] <= '0;
    end else if (ce) begin
      a_q      <= din0_i;
      b_q      <= din1_i;
      tag_q[0] <= tag_i;
      for (int i = 1; i < NUM_STAGE - 1; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  if (ProdRegs == 0) begin : g_comb
    assign prod_o = mult;
  end else begin : g_regs
    logic signed [ProdWidth-1:0] prod_q [ProdRegs];
    always_ff @(posedge clk) begin
      if (ce) begin
        prod_q[0] <= mult;
        for (int i = 1; i < ProdRegs; i++) prod_q[i] <= prod_q[i-1];
      end
    end
    assign prod_o = prod_q[ProdRegs-1];
  end

  assign tag_o = tag_q[NUM_STAGE-2];

endmodule

// File: rtl/cnn_mac_pipe_dsp.sv
// Pipelined signed multiply / multiply-accumulate with frame framing and optional saturation.
module cnn_mac_pipe_dsp import cnn_dsp_pkg::*; #(
  parameter int unsigned DIN0_WIDTH = 10,
  parameter int unsigned DIN1_WIDTH = 14,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned NUM_STAGE  = 3,
  parameter bit          SATURATE   = 1'b0
) (
  input logic               clk,
  input logic               reset,
  input logic               ce,
  cnn_mac_pipe_dsp_if.slave bus
);
  localparam int unsigned ProdWidth = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned SumWidth  = ACC_WIDTH + 1;

  beat_tag_t                   tag_in;
  beat_tag_t                   tag_out;
  logic signed [ProdWidth-1:0] prod;

  logic signed [SumWidth-1:0]  p_ext;
  logic signed [SumWidth-1:0]  base;
  logic signed [SumWidth-1:0]  sum;
  logic                        overflow;
  logic signed [ACC_WIDTH-1:0] acc_upd;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        ovf_r_q, ovf_r_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [ACC_WIDTH-1:0] dout_q, dout_d;
  logic                        out_last_q, out_last_d;
  logic                        ovf_q, ovf_d;

  assign tag_in = '{valid: bus.in_valid, mode: bus.acc_mode, first: bus.first, last: bus.last};

  cnn_mul_pipe_core #(
    .DIN0_WIDTH(DIN0_WIDTH),
    .DIN1_WIDTH(DIN1_WIDTH),
    .NUM_STAGE (NUM_STAGE)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .din0_i(bus.din0),
    .din1_i(bus.din1),
    .tag_i (tag_in),
    .prod_o(prod),
    .tag_o (tag_out)
  );

  // One guard bit: the sum fits ACC_WIDTH exactly when its top two bits agree.
  always_comb begin
    p_ext    = SumWidth'(prod);
    base     = tag_out.first ? '0 : SumWidth'(acc_q);
    sum      = base + p_ext;
    overflow = sum[SumWidth-1] ^ sum[SumWidth-2];
    acc_upd  = SATURATE ? ACC_WIDTH'(sat_clamp(64'(sum), ACC_WIDTH)) : sum[ACC_WIDTH-1:0];
  end

  always_comb begin
    acc_d       = acc_q;
    ovf_r_d     = ovf_r_q;
    out_valid_d = 1'b0;
    dout_d      = dout_q;
    out_last_d  = out_last_q;
    ovf_d       = ovf_q;
    if (tag_out.valid) begin
      if (tag_out.mode == MODE_MUL) begin
        out_valid_d = 1'b1;
        dout_d      = ACC_WIDTH'(prod);
        out_last_d  = tag_out.last;
        ovf_d       = 1'b0;
      end else begin
        acc_d   = acc_upd;
        ovf_r_d = (tag_out.first ? 1'b0 : ovf_r_q) | overflow;
        if (tag_out.last) begin
          out_valid_d = 1'b1;
          dout_d      = acc_upd;
          out_last_d  = 1'b1;
          ovf_d       = ovf_r_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      ovf_r_q     <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (ce) begin
      acc_q       <= acc_d;
      ovf_r_q     <= ovf_r_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      out_last_q  <= out_last_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.out_last  = out_last_q;
  assign bus.ovf       = ovf_q;

endmodule
